mem3: RTL and testbench
=======================

Name: mem3

Overview:
- Parametrised successor to the seat memory: a per-seat table holding a 2-bit state and a TIME_W timestamp.
- Validates each seat-state write against a legal transition set and flags illegal seating (do_not_seat).
- A background scanner frees AWAY seats whose hold time exceeds limit_time, one seat per cycle.
- Maintains a live free-seat count and a registered read-back port; sits between the kiosk/controller FSM and the display logic.

Parameters:
N_SEATS, 32, number of seats in the table (2..1024)
TIME_W, 11, timestamp width in bits
SEAT_W, $clog2(N_SEATS), seat index width (derived, not overridden)

Ports:
clk_mem3  in  1  clock, all logic on rising edge
rst_mem3  in  1  synchronous, active-high reset
clr_all  in  1  start full table clear (sampled in RUN only)
req_valid  in  1  seat write request
req_ready  out  1  table can accept a request
req_seat  in  SEAT_W  target seat
req_state  in  2  requested state: 00 FREE, 01 AWAY, 11 OCCUPIED, 10 illegal
cur_time  in  TIME_W  current time, free-running and wrapping
limit_time  in  TIME_W  AWAY hold limit
resp_valid  out  1  one-cycle pulse, one cycle after request acceptance
resp_reject  out  1  qualifies resp_valid: 1 = request refused
do_not_seat  out  1  one-cycle pulse: OCCUPIED requested on an OCCUPIED seat
expire_valid  out  1  one-cycle pulse: scanner freed a seat
expire_seat  out  SEAT_W  seat freed, valid with expire_valid
rd_seat  in  SEAT_W  read address
rd_state  out  2  state of rd_seat, 1-cycle latency
rd_time  out  TIME_W  timestamp of rd_seat, 1-cycle latency
free_count  out  $clog2(N_SEATS+1)  number of FREE seats

Behaviour:
- FSM states CLEAR and RUN. Reset forces CLEAR with clr_ptr=0.
- Reset values: req_ready=0, resp_valid=0, resp_reject=0, do_not_seat=0, expire_valid=0, expire_seat=0, rd_state=0, rd_time=0, free_count=N_SEATS, scan_ptr=0.
- CLEAR: writes state=FREE, time=0 to entry clr_ptr each cycle. After entry N_SEATS-1 the FSM moves to RUN, so CLEAR lasts exactly N_SEATS cycles.
- In CLEAR: req_ready=0, scanner idle, rd_* return the table contents (partially cleared data is permitted).
- RUN: req_ready=1. clr_all=1 in RUN → CLEAR next cycle, free_count reloaded to N_SEATS. A request accepted in that same cycle is completed first, but its free_count effect is discarded.
- A request is accepted when req_valid & req_ready.
- Legal transitions:
  - FREE→OCCUPIED
  - OCCUPIED→AWAY
  - AWAY→OCCUPIED
  - OCCUPIED→FREE
  - AWAY→FREE
  - same-state writes FREE→FREE and AWAY→AWAY (timestamp refresh)
- Rejected requests (table unchanged): FREE→AWAY, any req_state=10, req_seat ≥ N_SEATS, OCCUPIED→OCCUPIED.
- OCCUPIED→OCCUPIED additionally pulses do_not_seat together with resp_valid.
- On a legal write: state←req_state and time←cur_time. Response (resp_valid, resp_reject=0) follows one cycle after acceptance.
- free_count: +1 on a legal transition into FREE from non-FREE, −1 on FREE→OCCUPIED, +1 per scanner expiry. A request and an expiry in the same cycle are netted; the count never exceeds N_SEATS and never underflows.
- Scanner (RUN only): examines seat scan_ptr each cycle, then scan_ptr increments and wraps N_SEATS-1→0.
  - Elapsed time = (cur_time − time[scan_ptr]) mod 2^TIME_W, computed at TIME_W bits.
  - If state==AWAY and elapsed > limit_time (strict): state←FREE, expire_valid/expire_seat pulse next cycle.
  - elapsed == limit_time does not expire.
- Same-cycle conflict: if an accepted request targets scan_ptr, the request wins and the scanner takes no action on that seat this pass.
- Read port: rd_state/rd_time are registered from rd_seat and reflect writes committed up to the previous edge; there is no bypass. rd_seat ≥ N_SEATS returns 0.
- Reset mid-CLEAR or mid-request: restarts CLEAR from 0, and all pulses are squashed the next cycle.

Test Plan:
- Reset, N_SEATS=32 → req_ready=0 for exactly 32 cycles then 1; free_count=32; rd_state=00 for all seats.
- Seat 5: FREE→OCCUPIED at cur_time=100 → resp_valid, resp_reject=0, free_count=31; rd_seat=5 gives rd_state=11, rd_time=100.
- Seat 5 OCCUPIED, request 11 again → resp_reject=1 and do_not_seat=1 for one cycle; table and free_count unchanged.
- Seat 7 set to AWAY at cur_time=2040, limit_time=10, cur_time wrapping to 2:
  - at cur_time=2 (elapsed 10) → no expiry;
  - at elapsed 11 → expire_valid with expire_seat=7 within 32 cycles, rd_state=00, free_count incremented.
- Request to seat 9 issued in the cycle scan_ptr=9 with seat 9 expired-eligible AWAY, req 11 → seat becomes OCCUPIED, no expire pulse for 9.
- FREE→AWAY, req_state=10, and req_seat=40 with N_SEATS=32 → resp_reject=1, do_not_seat=0.
- clr_all with 3 seats occupied → 32 cycles req_ready=0, then free_count=32.

Source files
------------

// File: rtl/mem3_if.sv
// -----------------------------------------------------------------------------
// mem3_if - seat-write request/response bundle between the kiosk/controller FSM
// and the seat table.
//
//   req_valid   master -> slave  seat write request
//   req_ready   slave  -> master table can accept a request (RUN only)
//   req_seat    master -> slave  target seat index
//   req_state   master -> slave  requested state: 00 FREE, 01 AWAY, 11 OCCUPIED
//   resp_valid  slave  -> master one-cycle pulse, one cycle after acceptance
//   resp_reject slave  -> master qualifies resp_valid: 1 = request refused
//   do_not_seat slave  -> master pulse: OCCUPIED requested on an OCCUPIED seat
// -----------------------------------------------------------------------------
interface mem3_if #(
   parameter int N_SEATS = 32
);
   localparam int SEAT_W = $clog2(N_SEATS);

   logic              req_valid;
   logic              req_ready;
   logic [SEAT_W-1:0] req_seat;
   logic [1:0]        req_state;
   logic              resp_valid;
   logic              resp_reject;
   logic              do_not_seat;

   modport master (
      output req_valid, req_seat, req_state,
      input  req_ready, resp_valid, resp_reject, do_not_seat
   );

   modport slave (
      input  req_valid, req_seat, req_state,
      output req_ready, resp_valid, resp_reject, do_not_seat
   );
endinterface

// File: rtl/mem3.sv
// -----------------------------------------------------------------------------
// mem3 - per-seat state/timestamp table with transition checking, a background
// AWAY-expiry scanner, a live free-seat count and a registered read port.
//
//   clk_mem3      clock, all logic on the rising edge
//   rst_mem3      synchronous active-high reset (restarts the table clear)
//   clr_all       start a full table clear (honoured in RUN only)
//   kiosk         request/response bundle (mem3_if.slave)
//   cur_time      free-running, wrapping current time
//   limit_time    AWAY hold limit; a seat expires when elapsed > limit_time
//   expire_valid  pulse: the scanner freed expire_seat
//   expire_seat   seat freed, valid with expire_valid
//   rd_seat       read address; rd_state/rd_time follow one cycle later
//   free_count    number of FREE seats
// -----------------------------------------------------------------------------
module mem3 #(
   parameter int N_SEATS = 32,
   parameter int TIME_W  = 11
) (
   input  logic                         clk_mem3,
   input  logic                         rst_mem3,
   input  logic                         clr_all,
   mem3_if.slave                        kiosk,
   input  logic [TIME_W-1:0]            cur_time,
   input  logic [TIME_W-1:0]            limit_time,
   output logic                         expire_valid,
   output logic [$clog2(N_SEATS)-1:0]   expire_seat,
   input  logic [$clog2(N_SEATS)-1:0]   rd_seat,
   output logic [1:0]                   rd_state,
   output logic [TIME_W-1:0]            rd_time,
   output logic [$clog2(N_SEATS+1)-1:0] free_count
);
   localparam int SEAT_W = $clog2(N_SEATS);
   localparam int CNT_W  = $clog2(N_SEATS+1);

   localparam logic [SEAT_W:0]   SEAT_LIM  = (SEAT_W+1)'(N_SEATS);
   localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(N_SEATS-1);
   localparam logic [CNT_W:0]    CNT_LIM   = (CNT_W+1)'(N_SEATS);
   localparam logic [CNT_W:0]    CNT_ONE   = (CNT_W+1)'(1);

   typedef enum logic [1:0] {
      ST_FREE = 2'b00,
      ST_AWAY = 2'b01,
      ST_BAD  = 2'b10,
      ST_OCC  = 2'b11
   } seat_st_e;

   typedef enum logic {CLEAR, RUN} fsm_e;

   fsm_e              fsm_q, fsm_d;
   logic [SEAT_W-1:0] clr_ptr;
   logic [SEAT_W-1:0] scan_ptr;
   logic [1:0]        seat_state [N_SEATS];
   logic [TIME_W-1:0] seat_time  [N_SEATS];

   logic              running;
   logic              accept;
   logic              req_in_range;
   logic [SEAT_W-1:0] req_idx;
   logic [1:0]        cur_state;
   logic              legal;
   logic              seat_clash;
   logic              req_inc;
   logic              req_dec;
   logic [TIME_W-1:0] elapsed;
   logic              expire;
   logic [CNT_W:0]    count_next;
   logic              rd_in_range;
   logic [SEAT_W-1:0] rd_idx;

   assign running         = (fsm_q == RUN);
   assign kiosk.req_ready = running;
   assign accept          = kiosk.req_valid & running;

   // Out-of-range seats are refused; index 0 stands in so the table is never
   // addressed past its end.
   assign req_in_range = ({1'b0, kiosk.req_seat} < SEAT_LIM);
   assign req_idx      = req_in_range ? kiosk.req_seat : '0;
   assign cur_state    = seat_state[req_idx];
   assign rd_in_range  = ({1'b0, rd_seat} < SEAT_LIM);
   assign rd_idx       = rd_in_range ? rd_seat : '0;

   // NOTE: every variable written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         CLEAR:   if (clr_ptr == LAST_SEAT) fsm_d = RUN;
         RUN:     if (clr_all) fsm_d = CLEAR;
         default: fsm_d = CLEAR;
      endcase
   end

   always_comb begin
      legal = 1'b0;
      if (accept && req_in_range) begin
         case (cur_state)
            ST_FREE: legal = (kiosk.req_state == ST_FREE) || (kiosk.req_state == ST_OCC);
            ST_OCC:  legal = (kiosk.req_state == ST_AWAY) || (kiosk.req_state == ST_FREE);
            ST_AWAY: legal = (kiosk.req_state != ST_BAD);
            default: legal = 1'b0;
         endcase
      end
   end

   assign seat_clash = accept && req_in_range &&
                       (cur_state == ST_OCC) && (kiosk.req_state == ST_OCC);
   assign req_inc    = legal && (kiosk.req_state == ST_FREE) && (cur_state != ST_FREE);
   assign req_dec    = legal && (kiosk.req_state == ST_OCC) && (cur_state == ST_FREE);

   // Wrapping subtraction at TIME_W bits gives the hold time across a cur_time
   // rollover. A request to the seat under the scanner wins over the expiry.
   assign elapsed = cur_time - seat_time[scan_ptr];
   assign expire  = running && (seat_state[scan_ptr] == ST_AWAY) &&
                    (elapsed > limit_time) &&
                    !(accept && (kiosk.req_seat == scan_ptr));

   // Request and expiry effects are netted in one step, clamped to 0..N_SEATS.
   always_comb begin
      count_next = {1'b0, free_count} + {{CNT_W{1'b0}}, req_inc} + {{CNT_W{1'b0}}, expire};
      if (req_dec && (count_next != '0)) count_next = count_next - CNT_ONE;
      if (count_next > CNT_LIM) count_next = CNT_LIM;
   end

   // NOTE: the table has no reset; the CLEAR sweep initialises it, which keeps
   // it mappable onto RAM. Reset only blocks writes for that cycle.
   always_ff @(posedge clk_mem3) begin
      if (!rst_mem3) begin
         if (fsm_q == CLEAR) begin
            seat_state[clr_ptr] <= ST_FREE;
            seat_time[clr_ptr]  <= '0;
         end else begin
            if (legal) begin
               seat_state[req_idx] <= kiosk.req_state;
               seat_time[req_idx]  <= cur_time;
            end
            if (expire) seat_state[scan_ptr] <= ST_FREE;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_mem3) begin
      if (rst_mem3) begin
         fsm_q             <= CLEAR;
         clr_ptr           <= '0;
         scan_ptr          <= '0;
         kiosk.resp_valid  <= 1'b0;
         kiosk.resp_reject <= 1'b0;
         kiosk.do_not_seat <= 1'b0;
         expire_valid      <= 1'b0;
         expire_seat       <= '0;
         rd_state          <= '0;
         rd_time           <= '0;
         free_count        <= CNT_LIM[CNT_W-1:0];
      end else begin
         fsm_q             <= fsm_d;
         clr_ptr           <= ((fsm_q == CLEAR) && (clr_ptr != LAST_SEAT)) ? clr_ptr + 1'b1 : '0;
         kiosk.resp_valid  <= accept;
         kiosk.resp_reject <= accept && !legal;
         kiosk.do_not_seat <= seat_clash;
         expire_valid      <= expire;
         if (expire) expire_seat <= scan_ptr;
         rd_state          <= rd_in_range ? seat_state[rd_idx] : 2'b00;
         rd_time           <= rd_in_range ? seat_time[rd_idx] : '0;
         if (running) begin
            scan_ptr   <= (scan_ptr == LAST_SEAT) ? '0 : scan_ptr + 1'b1;
            // A clear discards this cycle's request/expiry count effects.
            free_count <= clr_all ? CNT_LIM[CNT_W-1:0] : count_next[CNT_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_mem3.sv
// -----------------------------------------------------------------------------
// tb_mem3 - self-checking bench for mem3 (N_SEATS=32, TIME_W=11) plus a small
// N_SEATS=20 instance for out-of-range seat indices. A seat-level model tracks
// the table, clear progress and scanner position; a negedge process compares
// every DUT output against it, and directed steps pin literal values.
// -----------------------------------------------------------------------------
module tb_mem3;
   localparam int N  = 32;
   localparam int NS = 20;
   localparam int TMOD = 2048;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_all = 1'b0;
   logic        s_clr = 1'b0;
   logic [10:0] cur_time = '0;
   logic [10:0] limit_time = 11'd10;
   logic [4:0]  rd_seat = '0;
   logic [4:0]  s_rd_seat = '0;
   logic        expire_valid, s_expire_valid;
   logic [4:0]  expire_seat, s_expire_seat;
   logic [1:0]  rd_state, s_rd_state;
   logic [10:0] rd_time, s_rd_time;
   logic [5:0]  free_count;
   logic [4:0]  s_free_count;

   mem3_if #(.N_SEATS(N))  m_if ();
   mem3_if #(.N_SEATS(NS)) s_if ();

   mem3 #(.N_SEATS(N), .TIME_W(11)) u_dut (
      .clk_mem3(clk), .rst_mem3(rst), .clr_all(clr_all), .kiosk(m_if.slave),
      .cur_time(cur_time), .limit_time(limit_time),
      .expire_valid(expire_valid), .expire_seat(expire_seat),
      .rd_seat(rd_seat), .rd_state(rd_state), .rd_time(rd_time),
      .free_count(free_count)
   );

   mem3 #(.N_SEATS(NS), .TIME_W(11)) u_small (
      .clk_mem3(clk), .rst_mem3(rst), .clr_all(s_clr), .kiosk(s_if.slave),
      .cur_time(cur_time), .limit_time(limit_time),
      .expire_valid(s_expire_valid), .expire_seat(s_expire_seat),
      .rd_seat(s_rd_seat), .rd_state(s_rd_state), .rd_time(s_rd_time),
      .free_count(s_free_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_state [N];
   int m_time  [N];
   bit m_known [N];
   int clear_left = N;
   int clr_pos = 0;
   int m_scan = 0;
   bit live = 0;
   int e_resp = 0, e_rej = 0, e_dns = 0, e_expv = 0, e_exps = 0;
   int e_rds = 0, e_rdt = 0;
   bit e_rdk = 0;

   function automatic bit legal_move(input int from, input int to);
      case (from)
         0:       return (to == 0) || (to == 3);
         3:       return (to == 1) || (to == 0);
         1:       return (to == 0) || (to == 1) || (to == 3);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int count_free();
      int n = 0;
      for (int i = 0; i < N; i++) if (m_state[i] == 0) n++;
      return n;
   endfunction

   always @(posedge clk) begin
      int s, el, seat, req;
      bit acc, hit;
      if (rst) begin
         clear_left = N; clr_pos = 0; m_scan = 0; live = 1;
         e_resp = 0; e_rej = 0; e_dns = 0; e_expv = 0; e_exps = 0;
         e_rds = 0; e_rdt = 0; e_rdk = 1;
      end else begin
         e_rdk = m_known[rd_seat];
         e_rds = m_state[rd_seat];
         e_rdt = m_time[rd_seat];
         e_resp = 0; e_rej = 0; e_dns = 0; e_expv = 0;
         if (clear_left > 0) begin
            m_state[clr_pos] = 0; m_time[clr_pos] = 0; m_known[clr_pos] = 1;
            clr_pos++; clear_left--;
         end else begin
            acc  = m_if.req_valid;
            seat = int'(m_if.req_seat);
            req  = int'(m_if.req_state);
            s    = m_scan;
            el   = ((int'(cur_time) - m_time[s]) % TMOD + TMOD) % TMOD;
            hit  = (m_state[s] == 1) && (el > int'(limit_time)) && !(acc && seat == s);
            if (acc) begin
               e_resp = 1;
               e_dns  = (m_state[seat] == 3) && (req == 3);
               if (legal_move(m_state[seat], req)) begin
                  m_state[seat] = req;
                  m_time[seat]  = int'(cur_time);
               end else e_rej = 1;
            end
            if (hit) begin
               m_state[s] = 0; e_expv = 1; e_exps = s;
            end
            if (clr_all) begin
               clear_left = N; clr_pos = 0;
            end
            m_scan = (m_scan + 1) % N;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         check("req_ready", int'(m_if.req_ready), int'(clear_left == 0));
         check("resp_valid", int'(m_if.resp_valid), e_resp);
         if (e_resp != 0) check("resp_reject", int'(m_if.resp_reject), e_rej);
         check("do_not_seat", int'(m_if.do_not_seat), e_dns);
         check("expire_valid", int'(expire_valid), e_expv);
         if (e_expv != 0) check("expire_seat", int'(expire_seat), e_exps);
         if (e_rdk) begin
            check("rd_state", int'(rd_state), e_rds);
            check("rd_time", int'(rd_time), e_rdt);
         end
         check("free_count", int'(free_count), (clear_left > 0) ? N : count_free());
      end
   end

   // ---------------- directed helpers ----------------
   int r_resp, r_rej, r_dns, r_free, r_expv;

   task automatic do_req(input int seat, input int st, input int t);
      @(negedge clk);
      m_if.req_valid = 1'b1;
      m_if.req_seat  = 5'(seat);
      m_if.req_state = 2'(st);
      cur_time       = 11'(t);
      @(posedge clk); #1;
      r_resp = int'(m_if.resp_valid); r_rej = int'(m_if.resp_reject);
      r_dns  = int'(m_if.do_not_seat); r_free = int'(free_count);
      r_expv = int'(expire_valid);
      m_if.req_valid = 1'b0;
   endtask

   task automatic rd_check(input int seat, input int es, input int et, input string nm);
      @(negedge clk);
      rd_seat = 5'(seat);
      @(posedge clk); #1;
      check({nm, "_state"}, int'(rd_state), es);
      check({nm, "_time"}, int'(rd_time), et);
   endtask

   // Counts cycles (sampled at negedge) with req_ready low, starting now.
   task automatic count_clear(output int n);
      n = 0;
      while (!m_if.req_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic count_expire(input int cycles, input int seat, output int hits);
      hits = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         if (expire_valid && int'(expire_seat) == seat) hits++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hits, k;
      bit found;
      m_if.req_valid = 1'b0; m_if.req_seat = '0; m_if.req_state = '0;
      s_if.req_valid = 1'b0; s_if.req_seat = '0; s_if.req_state = '0;

      // Reset, then exactly N cycles of CLEAR.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_free_count", int'(free_count), 32);
      check("reset_expire_seat", int'(expire_seat), 0);
      check("reset_resp_valid", int'(m_if.resp_valid), 0);
      count_clear(n);
      check("reset_clear_cycles", n, 32);
      check("after_clear_free", int'(free_count), 32);
      for (int i = 0; i < N; i++) rd_check(i, 0, 0, "init_rd");

      // Seat 5: FREE -> OCCUPIED, then a second OCCUPIED request.
      do_req(5, 3, 100);
      check("s5_resp", r_resp, 1);
      check("s5_reject", r_rej, 0);
      check("s5_free", r_free, 31);
      rd_check(5, 3, 100, "s5_rd");
      do_req(5, 3, 100);
      check("s5_dup_reject", r_rej, 1);
      check("s5_dup_dns", r_dns, 1);
      check("s5_dup_free", r_free, 31);
      @(posedge clk); #1;
      check("s5_dns_pulse_end", int'(m_if.do_not_seat), 0);
      rd_check(5, 3, 100, "s5_rd_after_dup");

      // Seat 7 AWAY at 2040, limit 10, time wraps.
      limit_time = 11'd10;
      do_req(7, 3, 2030);
      do_req(7, 1, 2040);
      check("s7_away_free", r_free, 30);
      @(negedge clk); cur_time = 11'd2;
      count_expire(40, 7, hits);
      check("s7_no_expire_at_limit", hits, 0);
      @(negedge clk); cur_time = 11'd3;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (expire_valid) begin
            found = 1;
            check("s7_expire_seat", int'(expire_seat), 7);
            check("s7_expire_free", int'(free_count), 31);
         end
      end
      check("s7_expire_seen", int'(found), 1);
      rd_check(7, 0, 2040, "s7_rd");

      // Seat 9: request lands in the cycle the scanner examines seat 9.
      do_req(9, 3, 3);
      do_req(9, 1, 3);
      k = 0;
      @(negedge clk);
      while (m_scan != 9 && k < 64) begin
         @(negedge clk);
         k++;
      end
      check("s9_scan_reached", int'(k < 64), 1);
      m_if.req_valid = 1'b1; m_if.req_seat = 5'd9; m_if.req_state = 2'd3;
      cur_time = 11'd100;
      @(posedge clk); #1;
      check("s9_reject", int'(m_if.resp_reject), 0);
      check("s9_no_expire", int'(expire_valid), 0);
      m_if.req_valid = 1'b0;
      count_expire(40, 9, hits);
      check("s9_no_expire_later", hits, 0);
      rd_check(9, 3, 100, "s9_rd");

      // Illegal requests.
      do_req(10, 1, 100);
      check("free_to_away_reject", r_rej, 1);
      check("free_to_away_dns", r_dns, 0);
      do_req(5, 2, 100);
      check("state10_reject", r_rej, 1);
      check("state10_dns", r_dns, 0);
      check("illegal_free", r_free, 30);

      // Out-of-range seat on the 20-seat instance.
      check("small_ready", int'(s_if.req_ready), 1);
      @(negedge clk);
      s_if.req_valid = 1'b1; s_if.req_seat = 5'd25; s_if.req_state = 2'd3;
      @(posedge clk); #1;
      check("small_oor_resp", int'(s_if.resp_valid), 1);
      check("small_oor_reject", int'(s_if.resp_reject), 1);
      check("small_oor_dns", int'(s_if.do_not_seat), 0);
      check("small_oor_free", int'(s_free_count), 20);
      @(negedge clk);
      s_if.req_seat = 5'd19;
      @(posedge clk); #1;
      check("small_19_reject", int'(s_if.resp_reject), 0);
      check("small_19_free", int'(s_free_count), 19);
      s_if.req_valid = 1'b0;
      @(negedge clk); s_rd_seat = 5'd25;
      @(posedge clk); #1;
      check("small_rd_oor_state", int'(s_rd_state), 0);
      check("small_rd_oor_time", int'(s_rd_time), 0);
      @(negedge clk); s_rd_seat = 5'd19;
      @(posedge clk); #1;
      check("small_rd_19_state", int'(s_rd_state), 3);
      check("small_rd_19_time", int'(s_rd_time), 100);

      // clr_all with three seats occupied and a same-cycle request.
      do_req(5, 0, 100);
      do_req(9, 0, 100);
      check("all_free_again", r_free, 32);
      do_req(1, 3, 100);
      do_req(2, 3, 100);
      do_req(3, 3, 100);
      check("three_occupied", r_free, 29);
      @(negedge clk);
      clr_all = 1'b1;
      m_if.req_valid = 1'b1; m_if.req_seat = 5'd4; m_if.req_state = 2'd3;
      @(posedge clk); #1;
      check("clr_req_resp", int'(m_if.resp_valid), 1);
      check("clr_req_reject", int'(m_if.resp_reject), 0);
      check("clr_free_reload", int'(free_count), 32);
      clr_all = 1'b0; m_if.req_valid = 1'b0;
      @(negedge clk);
      count_clear(n);
      check("clr_all_cycles", n, 32);
      check("clr_all_free", int'(free_count), 32);
      rd_check(1, 0, 0, "clr_rd1");
      rd_check(4, 0, 0, "clr_rd4");

      // Reset in the middle of a clear restarts it from seat 0.
      @(negedge clk); clr_all = 1'b1;
      @(negedge clk); clr_all = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      count_clear(n);
      check("reset_mid_clear_cycles", n, 32);

      // Randomised traffic, checked every cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         cur_time = cur_time + 11'($urandom_range(0, 3));
         if ((c % 256) == 0) limit_time = 11'($urandom_range(0, 40));
         m_if.req_valid = 1'($urandom_range(0, 1));
         m_if.req_seat  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7))
                                                      : 5'($urandom_range(0, 31));
         m_if.req_state = 2'($urandom_range(0, 3));
         rd_seat        = 5'($urandom_range(0, 31));
         clr_all        = ($urandom_range(0, 299) == 0);
         rst            = ($urandom_range(0, 999) == 0);
      end
      @(negedge clk);
      m_if.req_valid = 1'b0; clr_all = 1'b0; rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
